apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Upstream APB requester that drives the team's APB memory slave. It converts a simple valid/ready request port (one read or write per request) into legal APB SETUP/ACCESS sequences, waits for P_ready, and returns read data and error status on a one-cycle response strobe. A bounded wait timer ensures a hung slave can never stall the requester forever.

Parameters:
ADDR_W, 32, width of req_addr and P_addr
DATA_W, 32, width of write and read data paths
TIMEOUT_CYC, 16, maximum ACCESS cycles with P_ready=0 before abort; 0 disables the timeout

Ports:
P_clk  input  1  clock; all logic on rising edge
P_rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request (IDLE only)
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  transfer address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle strobe: transfer finished
rsp_rdata  output  DATA_W  read data; 0 for writes, errors and timeouts
rsp_slverr  output  1  slave error or timeout
rsp_timeout  output  1  transfer aborted by timer
P_addr  output  ADDR_W  APB address
P_selx  output  1  APB select
P_enable  output  1  APB enable
P_write  output  1  APB direction
P_wdata  output  DATA_W  APB write data
P_ready  input  1  slave ready
P_slverr  input  1  slave error, valid only with P_ready=1
P_rdata  input  DATA_W  slave read data

Behaviour:
- Reset (P_rst_n=0 at an edge): state=IDLE. All outputs 0, including req_ready, rsp_*, and all P_* signals. req_ready rises on the first clock edge after reset deasserts.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: req_ready=1, P_selx=0, P_enable=0. On req_valid&&req_ready at an edge:
  - register req_write, req_addr and req_wdata onto P_write, P_addr and P_wdata;
  - go to SETUP (P_selx=1, P_enable=0).
- SETUP: lasts exactly one cycle, then ACCESS (P_selx=1, P_enable=1). Wait counter cleared.
- ACCESS, edge with P_ready=1:
  - capture rsp_slverr=P_slverr;
  - capture rsp_rdata=P_rdata if read and P_slverr=0, else 0;
  - rsp_timeout=0 and rsp_valid=1 for one cycle;
  - P_selx=0, P_enable=0; go to IDLE.
- ACCESS, edge with P_ready=0: counter++. If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC, abort:
  - rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0;
  - P_selx=0, P_enable=0; go to IDLE.
- Timing with zero wait states: accept at edge T0, SETUP in T0–T1, ACCESS in T1–T2, rsp_valid high in T2–T3. req_ready is high again from T2, so the next accept can occur at T3. Each wait state adds one cycle.
- Signal stability: P_addr, P_write and P_wdata hold from accept until the next accept. They are not cleared in IDLE.
- rsp_rdata, rsp_slverr and rsp_timeout hold their last values until the next rsp_valid.
- While busy (req_ready=0), req_* inputs are ignored.
- P_slverr and P_rdata are ignored whenever P_ready=0.
- Reset mid-transfer: the bridge returns to IDLE and reset values on that edge. No rsp_valid is issued for the aborted transfer.
- Counter width: $clog2(TIMEOUT_CYC+1), minimum 1 bit. It saturates and never wraps.

Decomposition:
- Shared package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - default ADDR_W and DATA_W constants;
  - default TIMEOUT_CYC constant.
- One sub-module, apb_wait_timer: inputs clear, count-enable and limit; output expired. It is instantiated once for the ACCESS wait counter.

Test Plan:
- Write, zero-wait slave: req addr=1, wdata=7, write=1 -> P_selx=1/P_enable=0 for one cycle, then P_enable=1; rsp_valid 3 cycles after accept; rsp_slverr=0; rsp_rdata=0.
- Readback: write 7 to addr 1, then read addr 1 with 2 wait states -> ACCESS lasts 3 cycles; rsp_rdata=7; rsp_valid 5 cycles after accept.
- Slave error: slave returns P_ready=1, P_slverr=1 on a read of addr 0x20 -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYC=4, P_ready tied 0 -> abort after 4 ACCESS cycles; rsp_slverr=1, rsp_timeout=1; P_selx=0 next cycle; req_ready=1.
- Back-to-back with req_valid held high: writes to addr 1, 2, 3 -> accepts every 3 cycles; P_addr sequence 1, 2, 3; three rsp_valid pulses.
- Reset mid-ACCESS: drive P_rst_n=0 during a wait state -> next edge all outputs 0, no rsp_valid; after release, req_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master bridge.
package apb_pkg;

   localparam int unsigned APB_ADDR_W      = 32;
   localparam int unsigned APB_DATA_W      = 32;
   localparam int unsigned APB_TIMEOUT_CYC = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   // Wait-counter width for a given timeout; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned timeout_cyc);
      int unsigned w;
      w = $clog2(timeout_cyc + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; flags the wait that reaches the limit.
module apb_wait_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   count_inc;

   assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   // Combinational so the abort happens on the same edge the count reaches the limit.
   assign expired = en && (limit != '0) && (count_inc >= {1'b0, limit});

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB SETUP/ACCESS sequencer with bounded wait timeout.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = APB_ADDR_W,
   parameter int unsigned DATA_W      = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
   input  logic              P_clk,
   input  logic              P_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] P_addr,
   output logic              P_selx,
   output logic              P_enable,
   output logic              P_write,
   output logic [DATA_W-1:0] P_wdata,
   input  logic              P_ready,
   input  logic              P_slverr,
   input  logic [DATA_W-1:0] P_rdata
);

   localparam int unsigned      CNT_W = timer_width(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

   apb_state_e state, next_state;

   logic accept;
   logic expired;

   logic              req_ready_d;
   logic              rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic              rsp_slverr_d;
   logic              rsp_timeout_d;
   logic [ADDR_W-1:0] P_addr_d;
   logic              P_selx_d;
   logic              P_enable_d;
   logic              P_write_d;
   logic [DATA_W-1:0] P_wdata_d;

   assign accept = (state == IDLE) && req_valid && req_ready;

   apb_wait_timer #(
      .CNT_W (CNT_W)
   ) u_wait_timer (
      .clk     (P_clk),
      .rst_n   (P_rst_n),
      .clear   (state == SETUP),
      .en      ((state == ACCESS) && !P_ready),
      .limit   (LIMIT),
      .expired (expired)
   );

   always_ff @(posedge P_clk) begin
      if (!P_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept) next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (P_ready || expired) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are computed from next_state so every port is a plain flop.
   always_comb begin
      req_ready_d   = (next_state == IDLE);
      P_selx_d      = (next_state != IDLE);
      P_enable_d    = (next_state == ACCESS);
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata;
      rsp_slverr_d  = rsp_slverr;
      rsp_timeout_d = rsp_timeout;
      P_addr_d      = P_addr;
      P_write_d     = P_write;
      P_wdata_d     = P_wdata;

      if (accept) begin
         P_addr_d  = req_addr;
         P_write_d = req_write;
         P_wdata_d = req_wdata;
      end

      if ((state == ACCESS) && P_ready) begin
         rsp_valid_d   = 1'b1;
         rsp_slverr_d  = P_slverr;
         rsp_timeout_d = 1'b0;
         rsp_rdata_d   = (!P_write && !P_slverr) ? P_rdata : '0;
      end else if ((state == ACCESS) && expired) begin
         rsp_valid_d   = 1'b1;
         rsp_slverr_d  = 1'b1;
         rsp_timeout_d = 1'b1;
         rsp_rdata_d   = '0;
      end
   end

   always_ff @(posedge P_clk) begin
      if (!P_rst_n) begin
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         P_addr      <= '0;
         P_selx      <= 1'b0;
         P_enable    <= 1'b0;
         P_write     <= 1'b0;
         P_wdata     <= '0;
      end else begin
         req_ready   <= req_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_slverr  <= rsp_slverr_d;
         rsp_timeout <= rsp_timeout_d;
         P_addr      <= P_addr_d;
         P_selx      <= P_selx_d;
         P_enable    <= P_enable_d;
         P_write     <= P_write_d;
         P_wdata     <= P_wdata_d;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a transaction-level slave/memory model.
module tb_apb_master_bridge;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TO     = 4;

   logic              P_clk;
   logic              P_rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr;
   logic              rsp_timeout;
   logic [ADDR_W-1:0] P_addr;
   logic              P_selx;
   logic              P_enable;
   logic              P_write;
   logic [DATA_W-1:0] P_wdata;
   logic              P_ready;
   logic              P_slverr;
   logic [DATA_W-1:0] P_rdata;

   apb_master_bridge #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TO)
   ) dut (
      .P_clk       (P_clk),
      .P_rst_n     (P_rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .P_addr      (P_addr),
      .P_selx      (P_selx),
      .P_enable    (P_enable),
      .P_write     (P_write),
      .P_wdata     (P_wdata),
      .P_ready     (P_ready),
      .P_slverr    (P_slverr),
      .P_rdata     (P_rdata)
   );

   initial P_clk = 1'b0;
   always #5 P_clk = ~P_clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Slave memory contents as seen by completed, error-free writes.
   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check({tag, "_rsp_slverr"}, rsp_slverr, 0);
      check({tag, "_rsp_timeout"}, rsp_timeout, 0);
      check({tag, "_P_addr"}, P_addr, 0);
      check({tag, "_P_selx"}, P_selx, 0);
      check({tag, "_P_enable"}, P_enable, 0);
      check({tag, "_P_write"}, P_write, 0);
      check({tag, "_P_wdata"}, P_wdata, 0);
   endtask

   // One transfer: n counts negedges after the accepting posedge.
   // n=1 is SETUP, n>=2 is ACCESS; the response is visible at n=3+waits,
   // or at n=2+TO when the slave stalls for TO or more ACCESS cycles.
   task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int unsigned waits,
                       input logic err);
      logic              to;
      int unsigned       lat;
      int unsigned       n;
      logic [DATA_W-1:0] exp_rd;
      to     = (TO != 0) && (waits >= TO);
      lat    = to ? 2 + TO : 3 + waits;
      exp_rd = (!wr && !err && !to) ? mem_rd(addr) : '0;

      @(negedge P_clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge P_clk);
         n++;
      end
      check("req_ready_wait", req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end

      for (n = 1; n <= lat; n++) begin
         @(negedge P_clk);
         if (n < lat) begin
            check("busy_selx", P_selx, 1);
            check("busy_enable", P_enable, (n >= 2));
            check("busy_rsp_valid", rsp_valid, 0);
            check("busy_req_ready", req_ready, 0);
            check("busy_P_addr", P_addr, addr);
            check("busy_P_write", P_write, wr);
            check("busy_P_wdata", P_wdata, wdata);
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (n >= 2 && (n - 2) >= waits) begin
               P_ready  = 1'b1;
               P_slverr = err;
               P_rdata  = (wr || err) ? $urandom : mem_rd(addr);
            end else begin
               P_ready  = (n == 1) ? 1'($urandom) : 1'b0;
               P_slverr = 1'($urandom);
               P_rdata  = $urandom;
            end
         end else begin
            req_valid = 1'b0;
            P_ready   = 1'b0;
            P_slverr  = 1'($urandom);
            P_rdata   = $urandom;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_slverr", rsp_slverr, (err || to));
            check("rsp_timeout", rsp_timeout, to);
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("done_selx", P_selx, 0);
            check("done_enable", P_enable, 0);
            check("done_req_ready", req_ready, 1);
         end
      end

      @(negedge P_clk);
      check("pulse_end", rsp_valid, 0);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_slverr", rsp_slverr, (err || to));
      check("hold_timeout", rsp_timeout, to);
      check("hold_P_addr", P_addr, addr);
      if (wr && !err && !to) mem[addr] = wdata;
   endtask

   task automatic back_to_back();
      logic [ADDR_W-1:0] addrs [3];
      logic [DATA_W-1:0] datas [3];
      int unsigned k;
      int unsigned last;
      int unsigned pulses;
      addrs[0] = 1; addrs[1] = 2; addrs[2] = 3;
      for (int i = 0; i < 3; i++) datas[i] = $urandom;
      @(negedge P_clk);
      P_ready   = 1'b1;
      P_slverr  = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = addrs[0];
      req_wdata = datas[0];
      k = 0; last = 0; pulses = 0;
      for (int unsigned cyc = 1; cyc <= 12; cyc++) begin
         @(negedge P_clk);
         if (rsp_valid) pulses++;
         if (P_selx && !P_enable) begin
            if (k < 3) begin
               check("b2b_P_addr", P_addr, addrs[k]);
               check("b2b_P_wdata", P_wdata, datas[k]);
               check("b2b_cycle", cyc, 1 + 3 * k);
               mem[addrs[k]] = datas[k];
            end
            k++;
            if (k < 3) begin
               req_addr  = addrs[k];
               req_wdata = datas[k];
            end else begin
               req_valid = 1'b0;
            end
         end
         last = cyc;
      end
      check("b2b_setups", k, 3);
      check("b2b_pulses", pulses, 3);
      check("b2b_span", last, 12);
      P_ready = 1'b0;
   endtask

   task automatic reset_mid_access();
      int unsigned n;
      @(negedge P_clk);
      P_ready   = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 5;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge P_clk);
         n++;
      end
      check("rst_accept_ready", req_ready, 1);
      @(negedge P_clk);
      req_valid = 1'b0;
      repeat (2) @(negedge P_clk);
      check("rst_in_access", P_enable, 1);
      P_rst_n = 1'b0;
      @(negedge P_clk);
      check_all_zero("rst_mid");
      @(negedge P_clk);
      check("rst_hold_rsp_valid", rsp_valid, 0);
      P_rst_n = 1'b1;
      @(negedge P_clk);
      check("rst_release_ready", req_ready, 1);
      check("rst_release_rsp", rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      P_rst_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      P_ready   = 1'b0;
      P_slverr  = 1'b0;
      P_rdata   = '0;
      repeat (3) @(negedge P_clk);
      check_all_zero("reset");
      P_rst_n = 1'b1;
      @(negedge P_clk);
      check("ready_after_reset", req_ready, 1);

      xfer(1'b1, 32'h1, 32'h7, 0, 1'b0);
      xfer(1'b0, 32'h1, 32'h0, 2, 1'b0);
      xfer(1'b0, 32'h20, 32'h0, 0, 1'b1);
      xfer(1'b0, 32'h1, 32'h0, 10, 1'b0);
      xfer(1'b1, 32'h2, 32'h55, TO - 1, 1'b0);
      back_to_back();
      xfer(1'b0, 32'h3, 32'h0, 1, 1'b0);
      reset_mid_access();
      xfer(1'b1, 32'h4, 32'hABCD, 0, 1'b0);
      xfer(1'b0, 32'h4, 32'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         xfer(1'($urandom), ADDR_W'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 6), ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
